// File: rtl/dma_copy_master_pkg.sv
// Shared definitions for the DMA copy master.
//   - state_e    : controller state encoding (IDLE/RD/WR/FIN)
//   - BUS_W      : data/address bus width
//   - WORD_BYTES : byte stride between consecutive 32-bit words
package dma_copy_master_pkg;

  localparam int BUS_W      = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/dma_copy_master.sv
// DMA copy master: copies len 32-bit words from src_addr to dst_addr over the
// shared single-port data bus. Ownership is requested with bus_req and each
// bus cycle only takes effect when the arbiter returns bus_gnt. Each word
// costs one granted read cycle followed by one granted write cycle.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, abort        begin a copy (IDLE only) / cancel an active copy
//   src_addr, dst_addr  word-aligned byte addresses (bits [1:0] ignored)
//   len                 number of words to copy
//   bus_req, bus_gnt    ownership handshake with the external arbiter
//   bus_we, bus_addr,
//   bus_wd, bus_rd      data bus toward the decoder / read mux
//   busy, done          status: active, one-cycle completion pulse
//   words_left          remaining word count
module dma_copy_master
  import dma_copy_master_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [BUS_W-1:0] src_addr,
  input  logic [BUS_W-1:0] dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             bus_we,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wd,
  input  logic [BUS_W-1:0] bus_rd,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_left
);

  localparam logic [BUS_W-1:0] ALIGN_MASK = ~(BUS_W'(WORD_BYTES) - BUS_W'(1));
  localparam logic [BUS_W-1:0] STRIDE     = BUS_W'(WORD_BYTES);

  state_e           state_q, state_d;
  logic [BUS_W-1:0] src_q, src_d;
  logic [BUS_W-1:0] dst_q, dst_d;
  logic [BUS_W-1:0] data_q, data_d;
  logic [LEN_W-1:0] left_q, left_d;

  // Next-state and register update logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    left_d  = left_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort is deliberately not looked at here, so start wins over abort.
        if (start) begin
          src_d   = src_addr & ALIGN_MASK;
          dst_d   = dst_addr & ALIGN_MASK;
          left_d  = len;
          state_d = (len == '0) ? ST_FIN : ST_RD;
        end
      end
      ST_RD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus_gnt) begin
          data_d  = bus_rd;
          src_d   = src_q + STRIDE;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        // On abort the write is dropped and words_left is left untouched so
        // software can see how far the copy got.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus_gnt) begin
          dst_d   = dst_q + STRIDE;
          left_d  = left_q - LEN_W'(1);
          state_d = (left_q == LEN_W'(1)) ? ST_FIN : ST_RD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus and status outputs. Address and write data stay 0 outside RD/WR so
  // the CPU side of the shared decoder never sees stale DMA values.
  always_comb begin
    bus_req  = 1'b0;
    bus_we   = 1'b0;
    bus_addr = '0;
    bus_wd   = '0;
    done     = 1'b0;

    unique case (state_q)
      ST_RD: begin
        bus_req  = 1'b1;
        bus_addr = src_q;
      end
      ST_WR: begin
        bus_req  = 1'b1;
        bus_addr = dst_q;
        bus_wd   = data_q;
        bus_we   = bus_gnt & ~abort;
      end
      ST_FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign words_left = left_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      left_q  <= left_d;
    end
  end

endmodule
